// File: rtl/vector_player_pkg.sv
// vector_player_pkg: FSM state encoding and default parameters for vector_player
package vector_player_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_RESP_W = 8;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_STEP_CYCLES = 10;
endpackage

// File: rtl/vector_player_if.sv
// vector_player_if: stimulus/response bus between the player and the device under test
interface vector_player_if #(
  parameter int DATA_W = vector_player_pkg::DEF_DATA_W,
  parameter int RESP_W = vector_player_pkg::DEF_RESP_W
);
  logic [DATA_W-1:0] stim;
  logic              stim_valid;
  logic [RESP_W-1:0] resp;
  modport master (output stim, output stim_valid, input resp);
  modport slave (input stim, input stim_valid, output resp);
endinterface

// File: rtl/vector_player_mem.sv
// vector_player_mem: vector storage, one write port and one asynchronous read port, never reset
module vector_player_mem #(
  parameter int DEPTH = 16,
  parameter int W = 24,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clock) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/vector_player.sv
// vector_player: plays stored stimulus vectors, compares masked responses, counts mismatches.
// Define VECTOR_PLAYER_FIRST_FAIL_EN to add capture of the first mismatching sample.
module vector_player
  import vector_player_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RESP_W = DEF_RESP_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int STEP_CYCLES = DEF_STEP_CYCLES,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_en,
  input  logic [AW-1:0]     load_addr,
  input  logic [DATA_W-1:0] load_stim,
  input  logic [RESP_W-1:0] load_exp,
  input  logic [RESP_W-1:0] load_mask,
  input  logic              start,
  input  logic              stop,
  input  logic [AW:0]       run_len,
  vector_player_if.master   dut,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [AW:0]       err_count,
  output logic [AW-1:0]     vec_idx
`ifdef VECTOR_PLAYER_FIRST_FAIL_EN
  ,
  output logic              first_fail_valid,
  output logic [AW-1:0]     first_fail_idx,
  output logic [RESP_W-1:0] first_fail_resp
`endif
);
  localparam int EW = DATA_W + 2 * RESP_W;
  localparam int SW = STEP_CYCLES > 1 ? $clog2(STEP_CYCLES) : 1;
  state_t state, state_n;
  logic [SW-1:0] step;
  logic [AW-1:0] last_idx;
  logic [EW-1:0] cur, wdata, rdata, start_entry;
  logic [AW-1:0] raddr;
  logic we, go, smp, last, mis;
  assign we = load_en && state != RUN;
  assign go = start && state != RUN;
  assign smp = state == RUN && step == SW'(STEP_CYCLES - 1) && !stop;
  assign last = vec_idx == last_idx;
  assign mis = |((dut.resp ^ cur[2*RESP_W-1 -: RESP_W]) & cur[RESP_W-1:0]);
  assign wdata = {load_stim, load_exp, load_mask};
  // in RUN we prefetch the next vector; otherwise entry 0 for the coming start
  assign raddr = state == RUN ? vec_idx + AW'(1) : '0;
  assign start_entry = (we && load_addr == '0) ? wdata : rdata;
  vector_player_mem #(.DEPTH(DEPTH), .W(EW)) u_mem (
    .clock(clock), .we(we), .waddr(load_addr), .wdata(wdata), .raddr(raddr), .rdata(rdata)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state != RUN ? (start ? RUN : state) : stop ? IDLE : (smp && last) ? DONE : RUN;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      step <= '0;
      vec_idx <= '0;
      err_count <= '0;
      last_idx <= '0;
      cur <= '0;
    end else if (go) begin
      step <= '0;
      vec_idx <= '0;
      err_count <= '0;
      last_idx <= (run_len == '0 || run_len > (AW+1)'(DEPTH)) ? AW'(DEPTH - 1) : AW'(run_len - 1'b1);
      cur <= start_entry;
    end else if (smp) begin
      step <= '0;
      err_count <= err_count + (AW+1)'(mis);
      if (!last) begin
        vec_idx <= vec_idx + AW'(1);
        cur <= rdata;
      end
    end else if (state == RUN && !stop) step <= step + SW'(1);
`ifdef VECTOR_PLAYER_FIRST_FAIL_EN
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      first_fail_valid <= 1'b0;
      first_fail_idx <= '0;
      first_fail_resp <= '0;
    end else if (go) begin
      first_fail_valid <= 1'b0;
      first_fail_idx <= '0;
      first_fail_resp <= '0;
    end else if (smp && mis && !first_fail_valid) begin
      first_fail_valid <= 1'b1;
      first_fail_idx <= vec_idx;
      first_fail_resp <= dut.resp;
    end
`endif
  assign dut.stim = cur[EW-1 -: DATA_W];
  assign dut.stim_valid = state == RUN;
  assign busy = state == RUN;
  assign done = state == DONE;
  assign pass = state == DONE && err_count == '0;
endmodule

// File: tb/tb_vector_player.sv
// tb_vector_player: directed checks of vector_player with DEPTH=4, STEP_CYCLES=10
module tb_vector_player;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic load_en = 1'b0;
  logic [1:0] load_addr = '0;
  logic [7:0] load_stim = '0, load_exp = '0, load_mask = '0;
  logic start = 1'b0, stop = 1'b0;
  logic [2:0] run_len = '0;
  logic busy, done, pass;
  logic [2:0] err_count;
  logic [1:0] vec_idx;
  int checks = 0, failures = 0, cyc;
`ifdef VECTOR_PLAYER_FIRST_FAIL_EN
  logic ff_valid;
  logic [1:0] ff_idx;
  logic [7:0] ff_resp;
`endif
  vector_player_if #(.DATA_W(8), .RESP_W(8)) vif ();
  assign vif.resp = vif.stim;
  vector_player #(.DATA_W(8), .RESP_W(8), .DEPTH(4), .STEP_CYCLES(10)) dut (
    .clock(clock), .reset_n(reset_n), .load_en(load_en), .load_addr(load_addr),
    .load_stim(load_stim), .load_exp(load_exp), .load_mask(load_mask),
    .start(start), .stop(stop), .run_len(run_len), .dut(vif.master),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .vec_idx(vec_idx)
`ifdef VECTOR_PLAYER_FIRST_FAIL_EN
    , .first_fail_valid(ff_valid), .first_fail_idx(ff_idx), .first_fail_resp(ff_resp)
`endif
  );
  always #5 clock = ~clock;
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic load(input logic [1:0] a, input logic [7:0] s, input logic [7:0] e, input logic [7:0] m);
    load_en = 1'b1; load_addr = a; load_stim = s; load_exp = e; load_mask = m;
    tick(1);
    load_en = 1'b0;
  endtask
  task automatic start_run(input logic [2:0] len);
    run_len = len; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask
  task automatic wait_done(output int c);
    c = 0;
    while (busy && c < 200) begin
      c++;
      tick(1);
    end
  endtask
  task automatic idle_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_idx"}, vec_idx, 0);
    chk({tag, "_valid"}, vif.stim_valid, 0);
    chk({tag, "_stim"}, vif.stim, 0);
  endtask
  initial begin
    tick(2);
    idle_zero("reset");
    reset_n = 1'b1;
    tick(1);
    for (int i = 0; i < 4; i++) load(2'(i), 8'(i + 1), 8'(i + 1), 8'hFF);
    // basic all-match run over the full depth
    start_run(3'd4);
    chk("r1_stim0", vif.stim, 8'h01);
    chk("r1_valid", vif.stim_valid, 1);
    chk("r1_idx0", vec_idx, 0);
    chk("r1_done0", done, 0);
    wait_done(cyc);
    chk("r1_cycles", cyc, 40);
    chk("r1_done", done, 1);
    chk("r1_pass", pass, 1);
    chk("r1_err", err_count, 0);
    chk("r1_valid_off", vif.stim_valid, 0);
    chk("r1_stim_hold", vif.stim, 8'h04);
    chk("r1_idx_last", vec_idx, 3);
`ifdef VECTOR_PLAYER_FIRST_FAIL_EN
    chk("r1_ff_valid", ff_valid, 0);
`endif
    load(2'd2, 8'h03, 8'h07, 8'hFF);
    start_run(3'd4);
    wait_done(cyc);
    chk("r2_cycles", cyc, 40);
    chk("r2_err", err_count, 1);
    chk("r2_pass", pass, 0);
    chk("r2_done", done, 1);
`ifdef VECTOR_PLAYER_FIRST_FAIL_EN
    chk("r2_ff_valid", ff_valid, 1);
    chk("r2_ff_idx", ff_idx, 2);
    chk("r2_ff_resp", ff_resp, 8'h03);
`endif
    load(2'd2, 8'h03, 8'h07, 8'hF8);
    start_run(3'd4);
`ifdef VECTOR_PLAYER_FIRST_FAIL_EN
    chk("r3_ff_clear", ff_valid, 0);
`endif
    wait_done(cyc);
    chk("r3_err", err_count, 0);
    chk("r3_pass", pass, 1);
    start_run(3'd2);
    chk("r4_stim_c1", vif.stim, 8'h01);
    tick(9);
    chk("r4_stim_c10", vif.stim, 8'h01);
    chk("r4_idx_c10", vec_idx, 0);
    tick(1);
    chk("r4_stim_c11", vif.stim, 8'h02);
    chk("r4_idx_c11", vec_idx, 1);
    tick(9);
    chk("r4_busy_c20", busy, 1);
    chk("r4_done_c20", done, 0);
    tick(1);
    chk("r4_done_c21", done, 1);
    chk("r4_busy_c21", busy, 0);
    chk("r4_stim_c21", vif.stim, 8'h02);
    chk("r4_pass", pass, 1);
    start_run(3'd0);
    wait_done(cyc);
    chk("r5_len0_cycles", cyc, 40);
    chk("r5_len0_idx", vec_idx, 3);
    start_run(3'd7);
    wait_done(cyc);
    chk("r6_len7_cycles", cyc, 40);
    // stray start and load during RUN must be ignored; stop at cycle 15
    start_run(3'd4);
    tick(4);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    load(2'd3, 8'hAA, 8'hAA, 8'hFF);
    tick(8);
    chk("r7_idx_c15", vec_idx, 1);
    chk("r7_stim_c15", vif.stim, 8'h02);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("r7_stop_busy", busy, 0);
    chk("r7_stop_valid", vif.stim_valid, 0);
    chk("r7_stop_done", done, 0);
    chk("r7_stop_pass", pass, 0);
    stop = 1'b1;
    tick(2);
    stop = 1'b0;
    chk("r7_idle_stop_busy", busy, 0);
    start_run(3'd4);
    chk("r8_restart_idx", vec_idx, 0);
    chk("r8_restart_stim", vif.stim, 8'h01);
    wait_done(cyc);
    chk("r8_cycles", cyc, 40);
    chk("r8_stim_last", vif.stim, 8'h04);
    chk("r8_pass", pass, 1);
    // write and start on the same edge: run sees the new entry 0
    load_en = 1'b1; load_addr = 2'd0; load_stim = 8'h11; load_exp = 8'h11; load_mask = 8'hFF;
    start_run(3'd1);
    load_en = 1'b0;
    chk("r9_bypass_stim", vif.stim, 8'h11);
    wait_done(cyc);
    chk("r9_cycles", cyc, 10);
    chk("r9_pass", pass, 1);
    load(2'd0, 8'h01, 8'h01, 8'hFF);
    start_run(3'd4);
    tick(24);
    chk("r10_idx_c25", vec_idx, 2);
    reset_n = 1'b0;
    #1;
    idle_zero("areset");
    tick(2);
    reset_n = 1'b1;
    tick(1);
    chk("r10_post_busy", busy, 0);
    start_run(3'd4);
    wait_done(cyc);
    chk("r11_cycles", cyc, 40);
    chk("r11_pass", pass, 1);
    chk("r11_err", err_count, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vector_player.md
VECTOR_PLAYER -- requirements
Module: vector_player

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, stimulus width in bits.
REQ-002 The block SHALL have parameter RESP_W, default 8, response width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 16, vector memory entries (power of two, >=2); AW = log2(DEPTH).
REQ-004 The block SHALL have parameter STEP_CYCLES, default 10, number of cycles each vector is held (>=1).
REQ-005 The block SHALL have port clock, input, 1, the single clock, with all state on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have the load ports: load_en in 1; load_addr in AW; load_stim in DATA_W; load_exp in RESP_W; load_mask in RESP_W (1 = bit compared).
REQ-008 The block SHALL have the control ports: start in 1, begin run; stop in 1, abort run; run_len in AW+1, vectors to play (1..DEPTH).
REQ-009 The block SHALL have the DUT-side ports: stim out DATA_W, drives the DUT; stim_valid out 1, high while stim is meaningful; resp in RESP_W, DUT output.
REQ-010 The block SHALL have the status ports: busy out 1; done out 1; pass out 1; err_count out AW+1; vec_idx out AW, current vector.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-012 A load_en in IDLE or DONE SHALL write {stim, exp, mask} at load_addr on that edge; load_en in RUN SHALL be ignored.
REQ-013 start sampled in IDLE or DONE SHALL enter RUN next cycle with vec_idx=0, err_count=0, done=0, stim=entry 0, stim_valid=1.
REQ-014 start and load_en on the same edge SHALL commit the write first, so the run uses the new entry.
REQ-015 run_len SHALL be latched at start; a value of 0 or >DEPTH SHALL be treated as DEPTH.
REQ-016 Each vector SHALL drive stim for exactly STEP_CYCLES cycles; resp SHALL be sampled on the last cycle of that window.
REQ-017 A mismatch SHALL be ((resp ^ exp) & mask) != 0, and each mismatch SHALL increment err_count by 1.
REQ-018 After the sample, if vec_idx == latched_len-1 the FSM SHALL enter DONE; otherwise vec_idx SHALL increment and the next stim SHALL appear the following cycle with no gap.
REQ-019 Total RUN duration SHALL be latched_len*STEP_CYCLES cycles; done SHALL rise on the cycle after the final sample.
REQ-020 In DONE: done=1, pass=(err_count==0), stim_valid=0, and stim SHALL hold the last vector; all of these SHALL persist until start.
REQ-021 busy SHALL equal (state==RUN).
REQ-022 start during RUN SHALL be ignored.
REQ-023 stop in RUN SHALL return to IDLE next cycle with stim_valid=0, done=0, pass=0, and err_count held; stop has priority over a same-cycle final sample.
REQ-024 stop in IDLE or DONE SHALL have no effect.

Reset
REQ-025 reset_n low SHALL immediately force: state IDLE; stim=0; stim_valid=0; busy=0; done=0; pass=0; err_count=0; vec_idx=0.
REQ-026 Vector memory contents SHALL NOT be reset.
REQ-027 Reset during RUN SHALL abort with no further samples.

Configuration
REQ-028 With VECTOR_PLAYER_FIRST_FAIL_EN defined, the block SHALL add outputs first_fail_valid (1), first_fail_idx (AW), and first_fail_resp (RESP_W).
REQ-029 These outputs SHALL capture the first mismatching sample of a run, clear at start and at reset, and hold until the next start.
REQ-030 Without VECTOR_PLAYER_FIRST_FAIL_EN, these ports and their registers SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-031 Package vector_player_pkg SHALL hold the state enum (IDLE/RUN/DONE) and the default parameter constants.
REQ-032 Sub-module vector_player_mem SHALL implement the DEPTH x (DATA_W+2*RESP_W) register memory (one write port, one asynchronous read port); the FSM and the step counter SHALL live in the top level.

Verification (DATA_W=8, RESP_W=8, DEPTH=4, STEP_CYCLES=10)
REQ-033 Load stim {01,02,03,04}, exp = stim, mask FF; DUT resp = stim; start -> 40 cycles busy, then done=1, pass=1, err_count=0.
REQ-034 Same vectors, exp[2]=07 -> err_count=1, pass=0; with the macro: first_fail_idx=2, first_fail_resp=03.
REQ-035 exp[2]=07 with mask[2]=F8 -> resp 03 compares equal under mask -> pass=1.
REQ-036 run_len=2 -> stim shows 01 then 02, 10 cycles each; done at cycle 21; run_len=0 -> full 4 vectors played.
REQ-037 stop asserted at cycle 15 of a run -> IDLE next cycle, stim_valid=0, done=0; a later start restarts from vec_idx 0.
REQ-038 reset_n pulsed low at cycle 25 -> all outputs zero immediately; memory retained, so a re-start reproduces the REQ-033 result.
